// File: rtl/uart_rx_packer_if.sv
// Packet stream from the UART receiver to the matmul operand loader.
// The receiver drives valid/data through the master modport; the consumer returns ready.
interface uart_rx_packer_if #(
    parameter int W_OUT = 24
);
    logic             m_valid;
    logic             m_ready;
    logic [W_OUT-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/uart_rx_packer.sv
// UART receiver with start/stop/parity checking that packs NUM_WORDS serial words
// into one W_OUT-bit packet and offers it on a valid/ready stream with a holding register.
module uart_rx_packer #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 24,
    parameter bit PARITY_EN        = 1'b0,
    parameter bit PARITY_ODD       = 1'b0,
    parameter int STOP_BITS        = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    uart_rx_packer_if.master m,
    output logic             err_frame,
    output logic             err_parity,
    output logic             err_overrun
);
    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CW        = $clog2(CLOCKS_PER_PULSE);
    localparam int BW        = $clog2(BITS_PER_WORD + 1);
    localparam int WW        = $clog2(NUM_WORDS) + 1;

    localparam logic [CW-1:0] HALF_CNT  = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic             rx_meta, rx_s;
    logic [CW-1:0]    c_clocks, clocks_d;
    logic [BW-1:0]    c_bits, bits_d;
    logic [WW-1:0]    c_words;
    logic [W_OUT-1:0] sh, hold_q;
    logic             valid_q;
    logic             par_acc, par_bad, frm_bad;
    logic             shift_en, par_smp, stop_smp, word_end;
    logic             frame_now, word_ok, pkt_done, load;

    // Stage 0: line synchroniser, FSM state and bit-timing counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            state_q  <= IDLE;
            c_clocks <= '0;
            c_bits   <= '0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            state_q  <= state_d;
            c_clocks <= clocks_d;
            c_bits   <= bits_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clocks_d = (c_clocks == FULL_CNT) ? '0 : c_clocks + CW'(1);
        bits_d   = c_bits;
        shift_en = 1'b0;
        par_smp  = 1'b0;
        stop_smp = 1'b0;
        word_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                clocks_d = '0;
                bits_d   = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                // Half-bit re-check filters glitches and aligns later samples to mid-bit
                if (c_clocks == HALF_CNT) begin
                    clocks_d = '0;
                    state_d  = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (c_clocks == FULL_CNT) begin
                    shift_en = 1'b1;
                    bits_d   = c_bits + BW'(1);
                    if (c_bits == LAST_BIT) begin
                        bits_d  = '0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (c_clocks == FULL_CNT) begin
                    par_smp = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (c_clocks == FULL_CNT) begin
                    stop_smp = 1'b1;
                    bits_d   = c_bits + BW'(1);
                    // Leave at mid stop bit so a fast sender's next start edge is not missed
                    if (c_bits == LAST_STOP) begin
                        word_end = 1'b1;
                        bits_d   = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame_now = frm_bad | ~rx_s;
    assign word_ok   = word_end & ~frame_now & ~par_bad;
    assign pkt_done  = word_ok & (c_words == LAST_WORD);
    assign load      = pkt_done & (~valid_q | m.m_ready);

    // Stage 1: word assembly, packet hand-off and error pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh          <= '0;
            hold_q      <= '0;
            valid_q     <= 1'b0;
            c_words     <= '0;
            par_acc     <= 1'b0;
            par_bad     <= 1'b0;
            frm_bad     <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (shift_en) sh <= {rx_s, sh[W_OUT-1:1]};

            if (state_q == IDLE) begin
                par_acc <= 1'b0;
                par_bad <= 1'b0;
                frm_bad <= 1'b0;
            end else begin
                if (shift_en) par_acc <= par_acc ^ rx_s;
                if (par_smp)  par_bad <= ((par_acc ^ rx_s) != PARITY_ODD);
                if (stop_smp && !rx_s) frm_bad <= 1'b1;
            end

            if (word_end) c_words <= (word_ok && !pkt_done) ? c_words + WW'(1) : '0;

            err_frame   <= word_end & frame_now;
            err_parity  <= word_end & par_bad;
            err_overrun <= pkt_done & valid_q & ~m.m_ready;

            if (load) begin
                hold_q  <= sh;
                valid_q <= 1'b1;
            end else if (valid_q && m.m_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign m.m_valid = valid_q;
    assign m.m_data  = hold_q;
endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: three instances (plain, even parity, two stop bits)
// driven with hand-built UART frames; outputs are counted by a negedge monitor.
module tb_uart_rx_packer;
    localparam int CPP = 4;

    logic clk = 1'b0;
    logic rstn;
    logic rx_a, rx_p, rx_t;
    logic fe_a, pe_a, ov_a, fe_p, pe_p, ov_p, fe_t, pe_t, ov_t;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_rx_packer_if #(.W_OUT(24)) if_a ();
    uart_rx_packer_if #(.W_OUT(24)) if_p ();
    uart_rx_packer_if #(.W_OUT(24)) if_t ();

    uart_rx_packer #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(24),
                     .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_a (
        .clk(clk), .rstn(rstn), .rx(rx_a), .m(if_a.master),
        .err_frame(fe_a), .err_parity(pe_a), .err_overrun(ov_a));

    uart_rx_packer #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(24),
                     .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_par (
        .clk(clk), .rstn(rstn), .rx(rx_p), .m(if_p.master),
        .err_frame(fe_p), .err_parity(pe_p), .err_overrun(ov_p));

    uart_rx_packer #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(24),
                     .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_stop (
        .clk(clk), .rstn(rstn), .rx(rx_t), .m(if_t.master),
        .err_frame(fe_t), .err_parity(pe_t), .err_overrun(ov_t));

    // index 0: plain, 1: parity, 2: two stop bits
    logic [2:0]  vld, rdy, fe, pe, ov;
    logic [23:0] dat [3];
    assign vld    = {if_t.m_valid, if_p.m_valid, if_a.m_valid};
    assign rdy    = {if_t.m_ready, if_p.m_ready, if_a.m_ready};
    assign fe     = {fe_t, fe_p, fe_a};
    assign pe     = {pe_t, pe_p, pe_a};
    assign ov     = {ov_t, ov_p, ov_a};
    assign dat[0] = if_a.m_data;
    assign dat[1] = if_p.m_data;
    assign dat[2] = if_t.m_data;

    int          n_vld [3], n_xfer [3], n_fe [3], n_pe [3], n_ov [3];
    logic [23:0] last_xfer [3];
    int          s_vld [3], s_xfer [3], s_fe [3], s_pe [3], s_ov [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i])          n_vld[i]  <= n_vld[i] + 1;
            if (vld[i] && rdy[i]) begin
                n_xfer[i]    <= n_xfer[i] + 1;
                last_xfer[i] <= dat[i];
            end
            if (fe[i]) n_fe[i] <= n_fe[i] + 1;
            if (pe[i]) n_pe[i] <= n_pe[i] + 1;
            if (ov[i]) n_ov[i] <= n_ov[i] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap(input int i);
        s_vld[i]  = n_vld[i];
        s_xfer[i] = n_xfer[i];
        s_fe[i]   = n_fe[i];
        s_pe[i]   = n_pe[i];
        s_ov[i]   = n_ov[i];
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_t = v;
        endcase
    endtask

    task automatic hold_bit(input int sel, input logic v);
        set_rx(sel, v);
        repeat (CPP) @(negedge clk);
    endtask

    task automatic send_word(input int sel, input logic [7:0] d, input bit par_en,
                             input logic par_bit, input int nstop, input bit stop_low);
        hold_bit(sel, 1'b0);
        for (int b = 0; b < 8; b++) hold_bit(sel, d[b]);
        if (par_en) hold_bit(sel, par_bit);
        for (int s = 0; s < nstop; s++) hold_bit(sel, stop_low ? 1'b0 : 1'b1);
        hold_bit(sel, 1'b1);
        hold_bit(sel, 1'b1);
    endtask

    task automatic send_plain(input int sel, input logic [7:0] d, input int nstop);
        send_word(sel, d, 1'b0, 1'b0, nstop, 1'b0);
    endtask

    task automatic send_even(input logic [7:0] d);
        logic [7:0] tmp;
        tmp = d;
        send_word(1, d, 1'b1, ^tmp, 1, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        rx_a = 1'b1;
        rx_p = 1'b1;
        rx_t = 1'b1;
        if_a.m_ready = 1'b1;
        if_p.m_ready = 1'b1;
        if_t.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid_a", 32'(if_a.m_valid), 32'h0);
        check_eq("rst_data_a",  32'(if_a.m_data),  32'h0);
        check_eq("rst_valid_p", 32'(if_p.m_valid), 32'h0);
        check_eq("rst_valid_t", 32'(if_t.m_valid), 32'h0);
        check_eq("rst_errs",    32'({fe, pe, ov}), 32'h0);
        @(negedge clk) rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Basic packet with ready held high
        snap(0);
        send_plain(0, 8'h11, 1);
        send_plain(0, 8'h22, 1);
        send_plain(0, 8'h33, 1);
        check_eq("t1_data",   32'(last_xfer[0]),          32'h332211);
        check_eq("t1_xfer",   32'(n_xfer[0] - s_xfer[0]), 32'd1);
        check_eq("t1_vcyc",   32'(n_vld[0] - s_vld[0]),   32'd1);
        check_eq("t1_errs",   32'((n_fe[0] - s_fe[0]) + (n_pe[0] - s_pe[0]) + (n_ov[0] - s_ov[0])), 32'd0);

        // One-cycle glitch must not start a word
        snap(0);
        @(negedge clk) rx_a = 1'b0;
        @(negedge clk) rx_a = 1'b1;
        repeat (3 * CPP) @(negedge clk);
        check_eq("t2_glitch_fe", 32'(n_fe[0] - s_fe[0]), 32'd0);
        send_plain(0, 8'hAA, 1);
        send_plain(0, 8'hBB, 1);
        send_plain(0, 8'hCC, 1);
        check_eq("t2_data", 32'(last_xfer[0]),          32'hCCBBAA);
        check_eq("t2_xfer", 32'(n_xfer[0] - s_xfer[0]), 32'd1);

        // Parity error discards the partial packet
        snap(1);
        send_even(8'h09);
        send_word(1, 8'h01, 1'b1, 1'b0, 1, 1'b0);
        check_eq("t3_perr",  32'(n_pe[1] - s_pe[1]), 32'd1);
        check_eq("t3_nfe",   32'(n_fe[1] - s_fe[1]), 32'd0);
        send_even(8'h01);
        send_even(8'h02);
        send_even(8'h03);
        check_eq("t3_data",  32'(last_xfer[1]),          32'h030201);
        check_eq("t3_xfer",  32'(n_xfer[1] - s_xfer[1]), 32'd1);
        check_eq("t3_perr2", 32'(n_pe[1] - s_pe[1]),     32'd1);

        // Frame error on word 1, then full resend
        snap(0);
        send_plain(0, 8'h44, 1);
        send_word(0, 8'h55, 1'b0, 1'b0, 1, 1'b1);
        check_eq("t4_ferr", 32'(n_fe[0] - s_fe[0]),   32'd1);
        check_eq("t4_nvld", 32'(n_vld[0] - s_vld[0]), 32'd0);
        send_plain(0, 8'h44, 1);
        send_plain(0, 8'h55, 1);
        send_plain(0, 8'h66, 1);
        check_eq("t4_data", 32'(last_xfer[0]),          32'h665544);
        check_eq("t4_xfer", 32'(n_xfer[0] - s_xfer[0]), 32'd1);

        // Backpressure: first packet held, second dropped with overrun
        @(posedge clk);
        #1 if_a.m_ready = 1'b0;
        snap(0);
        send_plain(0, 8'h01, 1);
        send_plain(0, 8'h02, 1);
        send_plain(0, 8'h03, 1);
        check_eq("t5_valid1", 32'(if_a.m_valid), 32'h1);
        check_eq("t5_data1",  32'(if_a.m_data),  32'h030201);
        send_plain(0, 8'h04, 1);
        send_plain(0, 8'h05, 1);
        send_plain(0, 8'h06, 1);
        check_eq("t5_ovr",    32'(n_ov[0] - s_ov[0]),     32'd1);
        check_eq("t5_valid2", 32'(if_a.m_valid),          32'h1);
        check_eq("t5_hold",   32'(if_a.m_data),           32'h030201);
        check_eq("t5_noxfer", 32'(n_xfer[0] - s_xfer[0]), 32'd0);
        @(posedge clk);
        #1 if_a.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t5_xfer",   32'(n_xfer[0] - s_xfer[0]), 32'd1);
        check_eq("t5_xdata",  32'(last_xfer[0]),          32'h030201);
        check_eq("t5_vdrop",  32'(if_a.m_valid),          32'h0);

        // Two stop bits; reset mid-frame after one good word
        snap(2);
        send_plain(2, 8'h12, 2);
        send_plain(2, 8'h34, 2);
        send_plain(2, 8'h56, 2);
        check_eq("t6_pre", 32'(last_xfer[2]), 32'h563412);
        send_plain(2, 8'h99, 2);
        hold_bit(2, 1'b0);
        hold_bit(2, 1'b1);
        hold_bit(2, 1'b0);
        rstn = 1'b0;
        #1;
        check_eq("t6_rst_vld_t",  32'(if_t.m_valid), 32'h0);
        check_eq("t6_rst_data_t", 32'(if_t.m_data),  32'h0);
        check_eq("t6_rst_data_a", 32'(if_a.m_data),  32'h0);
        check_eq("t6_rst_errs",   32'({fe, pe, ov}), 32'h0);
        rx_t = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        snap(2);
        send_plain(2, 8'h7F, 2);
        send_plain(2, 8'h80, 2);
        send_plain(2, 8'hFF, 2);
        check_eq("t6_data", 32'(last_xfer[2]),          32'hFF807F);
        check_eq("t6_xfer", 32'(n_xfer[2] - s_xfer[2]), 32'd1);
        check_eq("t6_nfe",  32'(n_fe[2] - s_fe[2]),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
